// File: rtl/fetch_stage_pkg.sv
// rtl/fetch_stage_pkg.sv - shared instruction constants, field positions and field split helper
// Used by fetch, decode and hazard logic so every stage agrees on the encoding.
package fetch_stage_pkg;

  localparam logic [31:0] NOP_INSTR = 32'hE1A0_0000;

  localparam int COND_LSB       = 28;
  localparam int OP_LSB         = 26;
  localparam int FUNCT_LSB      = 20;
  localparam int RD_LSB         = 12;
  localparam int SHAMT5_LSB     = 7;
  localparam int SH_LSB         = 5;
  localparam int SHIFT_TYPE_BIT = 4;

  typedef struct packed {
    logic [3:0] cond;
    logic [1:0] op;
    logic [5:0] funct;
    logic [3:0] rd;
    logic [4:0] shamt5;
    logic [1:0] sh;
    logic       shift_type;
  } instr_fields_t;

  function automatic instr_fields_t split_fields(input logic [31:0] instr);
    instr_fields_t f;
    f.cond       = instr[COND_LSB +: 4];
    f.op         = instr[OP_LSB +: 2];
    f.funct      = instr[FUNCT_LSB +: 6];
    f.rd         = instr[RD_LSB +: 4];
    f.shamt5     = instr[SHAMT5_LSB +: 5];
    f.sh         = instr[SH_LSB +: 2];
    f.shift_type = instr[SHIFT_TYPE_BIT];
    return f;
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// rtl/fetch_stage_if.sv - instruction memory fetch bus between IF stage and imem
// master = fetch stage, slave = instruction memory.
interface fetch_stage_if #(
  parameter int BUS = 32
) ();

  logic [BUS-1:0] imem_addr;
  logic           imem_req;
  logic [31:0]    imem_rdata;
  logic           imem_ready;

  modport master (
    output imem_addr,
    output imem_req,
    input  imem_rdata,
    input  imem_ready
  );

  modport slave (
    input  imem_addr,
    input  imem_req,
    output imem_rdata,
    output imem_ready
  );

endinterface

// File: rtl/fetch_stage_if_id_reg.sv
// rtl/fetch_stage_if_id_reg.sv - IF/ID pipeline register with load, hold and bubble controls
// bubble wins over load; neither asserted means hold.
module if_id_reg
  import fetch_stage_pkg::*;
#(
  parameter int BUS = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           load_i,
  input  logic           bubble_i,
  input  logic [31:0]    instr_i,
  input  logic [BUS-1:0] pc_plus8_i,
  output logic           valid_o,
  output logic [31:0]    instr_o,
  output logic [BUS-1:0] pc_plus8_o
);

  logic           valid_q, valid_d;
  logic [31:0]    instr_q, instr_d;
  logic [BUS-1:0] pc_plus8_q, pc_plus8_d;

  always_comb begin
    valid_d    = valid_q;
    instr_d    = instr_q;
    pc_plus8_d = pc_plus8_q;
    if (bubble_i) begin
      // pc_plus8 is left as-is: it is meaningless while valid is low
      valid_d = 1'b0;
      instr_d = NOP_INSTR;
    end else if (load_i) begin
      valid_d    = 1'b1;
      instr_d    = instr_i;
      pc_plus8_d = pc_plus8_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q    <= 1'b0;
      instr_q    <= NOP_INSTR;
      pc_plus8_q <= '0;
    end else begin
      valid_q    <= valid_d;
      instr_q    <= instr_d;
      pc_plus8_q <= pc_plus8_d;
    end
  end

  assign valid_o    = valid_q;
  assign instr_o    = instr_q;
  assign pc_plus8_o = pc_plus8_q;

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - IF stage: PC register, next-PC mux, imem fetch and IF/ID register
// Redirects always update the PC, even under stall, so a resolved target is never lost.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int             bus      = 32,
  parameter logic [bus-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            flush,
  input  logic            branch_taken,
  input  logic [bus-1:0]  branch_target,
  input  logic            pc_wb_en,
  input  logic [bus-1:0]  pc_wb_value,
  fetch_stage_if.master   imem,
  output logic            id_valid,
  output logic [31:0]     id_instr,
  output logic [bus-1:0]  id_pc_plus8,
  output logic [3:0]      id_cond,
  output logic [1:0]      id_op,
  output logic [5:0]      id_funct,
  output logic [3:0]      id_rd,
  output logic [4:0]      id_shamt5,
  output logic [1:0]      id_sh,
  output logic            id_shift_type
);

  logic [bus-1:0] pc_q, pc_d;
  logic [bus-1:0] redirect_target;
  logic [bus-1:0] pc_plus4, pc_plus8;
  logic           redirect;
  logic           ifid_load, ifid_bubble;
  instr_fields_t  id_fields;

  assign pc_plus4 = pc_q + bus'(4);
  assign pc_plus8 = pc_q + bus'(8);

  // Writeback to R15 belongs to the older instruction, so it beats a branch.
  always_comb begin
    redirect        = pc_wb_en | branch_taken;
    redirect_target = pc_wb_en ? pc_wb_value : branch_target;
    redirect_target[1:0] = 2'b00;
    pc_d = pc_q;
    if (redirect) begin
      pc_d = redirect_target;
    end else if (!stall && imem.imem_ready) begin
      pc_d = pc_plus4;
    end
  end

  always_comb begin
    ifid_bubble = redirect | flush | (!stall && !imem.imem_ready);
    ifid_load   = !ifid_bubble && !stall;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign imem.imem_addr = pc_q;
  assign imem.imem_req  = !stall && !rst;

  if_id_reg #(
    .BUS (bus)
  ) u_if_id_reg (
    .clk        (clk),
    .rst        (rst),
    .load_i     (ifid_load),
    .bubble_i   (ifid_bubble),
    .instr_i    (imem.imem_rdata),
    .pc_plus8_i (pc_plus8),
    .valid_o    (id_valid),
    .instr_o    (id_instr),
    .pc_plus8_o (id_pc_plus8)
  );

  assign id_fields     = split_fields(id_instr);
  assign id_cond       = id_fields.cond;
  assign id_op         = id_fields.op;
  assign id_funct      = id_fields.funct;
  assign id_rd         = id_fields.rd;
  assign id_shamt5     = id_fields.shamt5;
  assign id_sh         = id_fields.sh;
  assign id_shift_type = id_fields.shift_type;

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - scoreboard bench for fetch_stage with directed and random stimulus
module tb_fetch_stage;

  localparam logic [31:0] NOP      = 32'hE1A0_0000;
  localparam logic [31:0] RST_PC   = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst, stall, flush, branch_taken, pc_wb_en;
  logic [31:0] branch_target, pc_wb_value;
  logic        id_valid;
  logic [31:0] id_instr, id_pc_plus8;
  logic [3:0]  id_cond, id_rd;
  logic [1:0]  id_op, id_sh;
  logic [5:0]  id_funct;
  logic [4:0]  id_shamt5;
  logic        id_shift_type;

  fetch_stage_if #(.BUS(32)) imem_if ();

  fetch_stage #(.bus(32), .RESET_PC(RST_PC)) dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .flush         (flush),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .pc_wb_en      (pc_wb_en),
    .pc_wb_value   (pc_wb_value),
    .imem          (imem_if.master),
    .id_valid      (id_valid),
    .id_instr      (id_instr),
    .id_pc_plus8   (id_pc_plus8),
    .id_cond       (id_cond),
    .id_op         (id_op),
    .id_funct      (id_funct),
    .id_rd         (id_rd),
    .id_shamt5     (id_shamt5),
    .id_sh         (id_sh),
    .id_shift_type (id_shift_type)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC3A5_0F1E;
  endfunction

  assign imem_if.imem_rdata = mem_word(imem_if.imem_addr);

  typedef struct {
    logic        valid;
    logic [31:0] instr;
    logic [31:0] pc8;
    bit          cmp_pc8;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;

  // reference model: architectural PC plus the expected IF/ID contents
  logic [31:0] m_pc;
  bit          m_pc_known = 0;
  logic        m_valid;
  logic [31:0] m_instr, m_pc8;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input bit r, input bit s, input bit f, input bit bt, input logic [31:0] bt_t,
                      input bit wb, input logic [31:0] wb_v, input bit rdy);
    exp_t e;
    @(negedge clk);
    rst = r; stall = s; flush = f; branch_taken = bt; branch_target = bt_t;
    pc_wb_en = wb; pc_wb_value = wb_v; imem_if.imem_ready = rdy;
    #1;
    if (m_pc_known && !r) check32("imem_addr", imem_if.imem_addr, m_pc);
    check32("imem_req", {31'd0, imem_if.imem_req}, {31'd0, !s && !r});
    if (r) begin
      m_pc = RST_PC; m_pc_known = 1; m_valid = 0; m_instr = NOP; m_pc8 = 0;
    end else if (wb || bt) begin
      m_pc = (wb ? wb_v : bt_t) & 32'hFFFF_FFFC;
      m_valid = 0; m_instr = NOP;
    end else if (f) begin
      m_valid = 0; m_instr = NOP;
      if (rdy && !s) m_pc = m_pc + 4;
    end else if (s) begin
      // hold everything
    end else if (rdy) begin
      m_valid = 1; m_instr = mem_word(m_pc); m_pc8 = m_pc + 8;
      m_pc = m_pc + 4;
    end else begin
      m_valid = 0; m_instr = NOP;
    end
    e.valid = m_valid; e.instr = m_instr; e.pc8 = m_pc8; e.cmp_pc8 = m_valid || r;
    exp_q.push_back(e);
  endtask

  task automatic run_seq(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 1);
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check32("id_valid", {31'd0, id_valid}, {31'd0, e.valid});
      check32("id_instr", id_instr, e.instr);
      check32("id_fields", {8'd0, id_cond, id_op, id_funct, id_rd, id_shamt5, id_sh, id_shift_type},
              {8'd0, e.instr[31:20], e.instr[15:4]});
      if (e.cmp_pc8) check32("id_pc_plus8", id_pc_plus8, e.pc8);
    end
  end

  initial begin
    rst = 1; stall = 0; flush = 0; branch_taken = 0; pc_wb_en = 0;
    branch_target = 0; pc_wb_value = 0; imem_if.imem_ready = 0;

    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    run_seq(5);

    // branch under stall: target captured, IF/ID bubbles, fetch resumes at target
    step(0, 1, 0, 1, 32'h100, 0, 0, 1);
    step(0, 1, 0, 0, 0, 0, 0, 1);
    step(0, 1, 0, 0, 0, 0, 0, 1);
    run_seq(3);

    // writeback to R15 beats a concurrent branch; low bits of target dropped
    step(0, 0, 0, 1, 32'h300, 1, 32'h200, 1);
    run_seq(2);
    step(0, 0, 0, 1, 32'h403, 0, 0, 1);
    run_seq(2);

    // memory wait bubbles
    step(0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    run_seq(2);

    // flush with and without stall
    step(0, 0, 1, 0, 0, 0, 0, 1);
    step(0, 1, 1, 0, 0, 0, 0, 1);
    run_seq(2);

    // PC wrap, then reset while stalled
    step(0, 0, 0, 1, 32'hFFFF_FFF8, 0, 0, 1);
    run_seq(3);
    step(1, 1, 0, 0, 0, 0, 0, 1);
    run_seq(2);

    for (int i = 0; i < 400; i++) begin
      step(($urandom % 60) == 0, ($urandom % 4) == 0, ($urandom % 8) == 0,
           ($urandom % 10) == 0, $urandom, ($urandom % 16) == 0, $urandom,
           ($urandom % 5) != 0);
    end
    run_seq(2);

    repeat (3) @(posedge clk);
    #2;
    check32("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
